// File: rtl/dmadd_sequencer_if.sv
// Host-side operand, job and result handshakes of dmadd_sequencer.
// master = host control logic, slave = sequencer.
interface dmadd_sequencer_if;
  logic        op_valid, op_ready;
  logic [3:0]  op_index, op_data;
  logic        go_valid, go_ready;
  logic [1:0]  go_insn;
  logic        res_valid, res_ready;
  logic [11:0] res_data;
  logic        res_err;

  modport master (
    output op_valid, op_index, op_data, go_valid, go_insn, res_ready,
    input  op_ready, go_ready, res_valid, res_data, res_err
  );
  modport slave (
    input  op_valid, op_index, op_data, go_valid, go_insn, res_ready,
    output op_ready, go_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/dmadd_sequencer.sv
// Command-side initiator for the DMADD engine: operand FIFO, clear/init/load/run pin sequencing, result capture.
// Optional DMADD_SEQ_STATS_EN adds job_count and drop_flag outputs.
module dmadd_sequencer #(
  parameter int DEPTH      = 8,
  parameter int RUN_CYCLES = 17
) (
  input  logic        clk,
  input  logic        rst,
  dmadd_sequencer_if.slave host,
  output logic        dmadd_rst_n,
  output logic        dmadd_run,
  output logic        dmadd_load,
  output logic [1:0]  dmadd_insn,
  output logic [3:0]  dmadd_index,
  output logic [3:0]  dmadd_data,
  input  logic [11:0] result_in
`ifdef DMADD_SEQ_STATS_EN
  ,
  output logic [7:0]  job_count,
  output logic [0:0]  drop_flag
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam logic [1:0] INSN_MADD = 2'b10;
  localparam logic [1:0] INSN_ILL  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_INIT, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [RW-1:0] run_cnt;
  logic          push, pop, go_acc, go_ill;

  assign push   = host.op_valid && host.op_ready;
  assign go_acc = host.go_valid && host.go_ready;
  assign go_ill = go_acc && (host.go_insn == INSN_ILL);

  // Outputs are registered from state_nxt so each pin lines up with its state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (go_acc) state_nxt = go_ill ? S_DONE : S_CLR;
      S_CLR:  if (dmadd_insn != INSN_MADD) state_nxt = S_INIT;
              else state_nxt = (count != '0) ? S_LOAD : S_RUN;
      S_INIT: state_nxt = (count != '0) ? S_LOAD : S_RUN;
      S_LOAD: state_nxt = (count != '0) ? S_LOAD : S_RUN;
      S_RUN:  if (run_cnt == '0) state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_DONE;
      S_DONE: if (host.res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    pop       = (state_nxt == S_LOAD);
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {host.op_index, host.op_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      run_cnt        <= '0;
      dmadd_rst_n    <= 1'b0;
      dmadd_run      <= 1'b0;
      dmadd_load     <= 1'b0;
      dmadd_insn     <= '0;
      dmadd_index    <= '0;
      dmadd_data     <= '0;
      host.op_ready  <= 1'b0;
      host.go_ready  <= 1'b0;
      host.res_valid <= 1'b0;
      host.res_err   <= 1'b0;
      host.res_data  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state != S_RUN)      run_cnt <= RW'(RUN_CYCLES - 1);
      else if (run_cnt != '0)  run_cnt <= run_cnt - 1'b1;

      dmadd_rst_n <= (state_nxt != S_CLR);
      dmadd_run   <= (state_nxt == S_RUN);
      dmadd_load  <= pop;
      if (pop) {dmadd_index, dmadd_data} <= mem[rd_ptr];
      if (go_acc && !go_ill) dmadd_insn <= host.go_insn;

      host.op_ready  <= (state_nxt == S_IDLE) && (count_nxt != CW'(DEPTH));
      host.go_ready  <= (state_nxt == S_IDLE);
      host.res_valid <= (state_nxt == S_DONE);
      // An illegal job reports straight away with a zero payload.
      if (go_acc) begin
        host.res_err  <= go_ill;
        host.res_data <= '0;
      end else if (state == S_WAIT) begin
        host.res_data <= result_in;
      end
    end
  end

`ifdef DMADD_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      job_count <= '0;
      drop_flag <= '0;
    end else begin
      if (host.res_valid && host.res_ready && !host.res_err) job_count <= job_count + 1'b1;
      if (host.op_valid && !host.op_ready && state != S_IDLE) drop_flag <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dmadd_sequencer.sv
// Self-checking bench for dmadd_sequencer: engine stub on result_in, scoreboard of expected results.
`timescale 1ns/1ps
module tb_dmadd_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmadd_sequencer_if h();
  logic        dmadd_rst_n, dmadd_run, dmadd_load;
  logic [1:0]  dmadd_insn;
  logic [3:0]  dmadd_index, dmadd_data;
  logic [11:0] result_in;
`ifdef DMADD_SEQ_STATS_EN
  logic [7:0]  job_count;
  logic [0:0]  drop_flag;
`endif

  dmadd_sequencer #(.DEPTH(8), .RUN_CYCLES(17)) dut (
    .clk(clk), .rst(rst), .host(h),
    .dmadd_rst_n(dmadd_rst_n), .dmadd_run(dmadd_run), .dmadd_load(dmadd_load),
    .dmadd_insn(dmadd_insn), .dmadd_index(dmadd_index), .dmadd_data(dmadd_data),
    .result_in(result_in)
`ifdef DMADD_SEQ_STATS_EN
    , .job_count(job_count), .drop_flag(drop_flag)
`endif
  );

  typedef struct packed { logic err; logic [11:0] data; } res_t;
  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   jobs_ok = 0;
  int   lat;
  logic       tr_rstn[64], tr_load[64], tr_run[64];
  logic [1:0] tr_insn[64];
  logic [3:0] tr_idx[64], tr_dat[64];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic [3:0] i, input logic [3:0] d);
    h.op_valid = 1'b1; h.op_index = i; h.op_data = d;
    tick();
    h.op_valid = 1'b0;
  endtask

  task automatic record(input int k);
    tr_rstn[k] = dmadd_rst_n; tr_load[k] = dmadd_load; tr_run[k] = dmadd_run;
    tr_insn[k] = dmadd_insn;  tr_idx[k]  = dmadd_index; tr_dat[k] = dmadd_data;
  endtask

  // Issue a job (optionally with a same-cycle operand) and trace pins until res_valid.
  task automatic go_job(input logic [1:0] insn, input bit with_op,
                        input logic [3:0] i, input logic [3:0] d);
    h.go_valid = 1'b1; h.go_insn = insn;
    if (with_op) begin h.op_valid = 1'b1; h.op_index = i; h.op_data = d; end
    tick();
    h.go_valid = 1'b0; h.op_valid = 1'b0;
    lat = 0;
    record(0);
    while (!h.res_valid && lat < 60) begin
      tick(); lat++; record(lat);
    end
  endtask

  task automatic take_result(input string name);
    res_t e;
    checks++;
    if (!h.res_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_avail: res_valid=%0b expected_entries=%0d", name, h.res_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (h.res_err !== e.err || h.res_data !== e.data) begin
        errors++;
        $display("FAIL %s_result: got err=%0b data=%h want err=%0b data=%h",
                 name, h.res_err, h.res_data, e.err, e.data);
      end
      if (!e.err) jobs_ok++;
    end
    h.res_ready = 1'b1;
    tick();
    h.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({dmadd_rst_n, dmadd_run, dmadd_load, dmadd_insn, dmadd_index, dmadd_data,
           h.res_valid, h.res_err, h.res_data, h.op_ready, h.go_ready} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d rst_n=%0b run=%0b load=%0b rv=%0b opr=%0b gor=%0b want all 0",
                 c, dmadd_rst_n, dmadd_run, dmadd_load, h.res_valid, h.op_ready, h.go_ready);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({dmadd_rst_n, h.op_ready, h.go_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: rst_n=%0b op_ready=%0b go_ready=%0b want 1 1 1",
               dmadd_rst_n, h.op_ready, h.go_ready);
    end
  endtask

  task automatic test_min();
    int loads;
    result_in = 12'd3;
    enq(4'd5, 4'd0); enq(4'd9, 4'd0);
    exp_q.push_back('{err: 1'b0, data: 12'd3});
    go_job(2'b00, 1'b1, 4'd3, 4'd0);
    checks++;
    if (lat !== 23) begin errors++; $display("FAIL min_latency: got %0d want 23", lat); end
    checks++;
    if (tr_rstn[0] !== 1'b0 || tr_rstn[1] !== 1'b1 || tr_load[1] !== 1'b0 || tr_run[1] !== 1'b0) begin
      errors++;
      $display("FAIL min_clr_init: rst_n=%0b,%0b load1=%0b run1=%0b want 0,1 0 0",
               tr_rstn[0], tr_rstn[1], tr_load[1], tr_run[1]);
    end
    loads = 0;
    for (int k = 0; k <= lat && k < 64; k++) if (tr_load[k]) loads++;
    checks++;
    if (loads !== 3 || tr_idx[2] !== 4'd5 || tr_idx[3] !== 4'd9 || tr_idx[4] !== 4'd3) begin
      errors++;
      $display("FAIL min_loads: count=%0d idx=%0d,%0d,%0d want 3 with 5,9,3",
               loads, tr_idx[2], tr_idx[3], tr_idx[4]);
    end
    take_result("min");
  endtask

  task automatic test_madd();
    int loads, runs, clrs, bad_insn;
    result_in = 12'h0A5;
    enq(4'd4, 4'd1); enq(4'd7, 4'd2);
    exp_q.push_back('{err: 1'b0, data: 12'h0A5});
    go_job(2'b10, 1'b0, 4'd0, 4'd0);
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL madd_latency: got %0d want 21", lat); end
    loads = 0; runs = 0; clrs = 0; bad_insn = 0;
    for (int k = 0; k <= lat && k < 64; k++) begin
      if (tr_load[k]) loads++;
      if (tr_run[k]) runs++;
      if (!tr_rstn[k]) clrs++;
      if (tr_insn[k] !== 2'b10) bad_insn++;
    end
    checks++;
    if (clrs !== 1 || tr_rstn[0] !== 1'b0) begin
      errors++; $display("FAIL madd_clr: clr cycles=%0d first=%0b want 1 and 0", clrs, tr_rstn[0]);
    end
    checks++;
    if (loads !== 2 || tr_load[1] !== 1'b1 || {tr_idx[1], tr_dat[1], tr_idx[2], tr_dat[2]} !== 16'h4172) begin
      errors++;
      $display("FAIL madd_loads: count=%0d first_load_at1=%0b pairs=%h,%h,%h,%h want 2 1 4,1,7,2",
               loads, tr_load[1], tr_idx[1], tr_dat[1], tr_idx[2], tr_dat[2]);
    end
    checks++;
    if (runs !== 17) begin errors++; $display("FAIL madd_run: got %0d cycles want 17", runs); end
    checks++;
    if (bad_insn !== 0) begin errors++; $display("FAIL madd_insn: %0d cycles not 10", bad_insn); end
    take_result("madd");
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 8; i++) enq(4'(i), 4'(15 - i));
    checks++;
    if (h.op_ready !== 1'b0) begin errors++; $display("FAIL bp_full: op_ready=%0b want 0", h.op_ready); end
    result_in = 12'h123;
    exp_q.push_back('{err: 1'b0, data: 12'h123});
    go_job(2'b10, 1'b0, 4'd0, 4'd0);
    checks++;
    if (lat !== 27) begin errors++; $display("FAIL bp_latency: got %0d want 27", lat); end
    bad = 0;
    for (int k = 0; k < 8; k++) if (tr_idx[1+k] !== 4'(k) || tr_dat[1+k] !== 4'(15 - k)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_order: %0d entries out of order", bad); end
`ifdef DMADD_SEQ_STATS_EN
    checks++;
    if (drop_flag !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0b want 0", drop_flag); end
`endif
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      result_in = 12'($urandom);
      h.op_valid = (c == 0);
      tick();
      if (h.res_valid !== 1'b1 || h.res_data !== 12'h123 || h.go_ready !== 1'b0 || h.op_ready !== 1'b0) bad++;
    end
    h.op_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
`ifdef DMADD_SEQ_STATS_EN
    checks++;
    if (drop_flag !== 1'b1) begin errors++; $display("FAIL drop_set: got %0b want 1", drop_flag); end
`endif
    take_result("bp");
    checks++;
    if (h.res_valid !== 1'b0 || h.go_ready !== 1'b1 || h.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: res_valid=%0b go_ready=%0b op_ready=%0b want 0 1 1",
               h.res_valid, h.go_ready, h.op_ready);
    end
  endtask

  task automatic test_illegal();
    int loads;
    enq(4'd2, 4'd2); enq(4'd6, 4'd6);
    exp_q.push_back('{err: 1'b1, data: 12'h000});
    go_job(2'b11, 1'b0, 4'd0, 4'd0);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL ill_latency: got %0d want 0", lat); end
    checks++;
    if (tr_rstn[0] !== 1'b1 || tr_load[0] !== 1'b0 || tr_run[0] !== 1'b0 || tr_insn[0] !== 2'b10) begin
      errors++;
      $display("FAIL ill_pins: rst_n=%0b load=%0b run=%0b insn=%b want 1 0 0 10",
               tr_rstn[0], tr_load[0], tr_run[0], tr_insn[0]);
    end
    take_result("ill");
    result_in = 12'h7FF;
    exp_q.push_back('{err: 1'b0, data: 12'h7FF});
    go_job(2'b10, 1'b0, 4'd0, 4'd0);
    loads = 0;
    for (int k = 0; k <= lat && k < 64; k++) if (tr_load[k]) loads++;
    checks++;
    if (loads !== 2 || {tr_idx[1], tr_dat[1], tr_idx[2], tr_dat[2]} !== 16'h2266) begin
      errors++;
      $display("FAIL ill_fifo_kept: loads=%0d pairs=%h,%h,%h,%h want 2 2,2,6,6",
               loads, tr_idx[1], tr_dat[1], tr_idx[2], tr_dat[2]);
    end
    take_result("ill_follow");
  endtask

  task automatic test_reset_mid_run();
    int runs, guard, loads;
`ifdef DMADD_SEQ_STATS_EN
    checks++;
    if (job_count !== 8'(jobs_ok)) begin
      errors++; $display("FAIL job_count: got %0d want %0d", job_count, jobs_ok);
    end
`endif
    enq(4'd1, 4'd1);
    result_in = 12'h321;
    exp_q.push_back('{err: 1'b0, data: 12'h321});
    h.go_valid = 1'b1; h.go_insn = 2'b10;
    tick();
    h.go_valid = 1'b0;
    runs = 0; guard = 0;
    while (runs < 5 && guard < 40) begin
      tick(); guard++;
      if (dmadd_run) runs++;
    end
    checks++;
    if (runs !== 5) begin errors++; $display("FAIL mid_reach_run: got %0d run cycles want 5", runs); end
    rst = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if (dmadd_run !== 1'b0 || dmadd_rst_n !== 1'b0 || h.res_valid !== 1'b0 || h.op_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: run=%0b rst_n=%0b res_valid=%0b op_ready=%0b want 0 0 0 0",
               dmadd_run, dmadd_rst_n, h.res_valid, h.op_ready);
    end
    tick();
    checks++;
    if (dmadd_rst_n !== 1'b0) begin errors++; $display("FAIL mid_hold: rst_n=%0b want 0", dmadd_rst_n); end
    rst = 1'b0;
    tick();
    jobs_ok = 0;
`ifdef DMADD_SEQ_STATS_EN
    checks++;
    if (job_count !== 8'd0 || drop_flag !== 1'b0) begin
      errors++; $display("FAIL mid_stats: job_count=%0d drop=%0b want 0 0", job_count, drop_flag);
    end
`endif
    result_in = 12'h055;
    exp_q.push_back('{err: 1'b0, data: 12'h055});
    go_job(2'b10, 1'b0, 4'd0, 4'd0);
    loads = 0;
    for (int k = 0; k <= lat && k < 64; k++) if (tr_load[k]) loads++;
    checks++;
    if (lat !== 19 || loads !== 0) begin
      errors++; $display("FAIL mid_fifo_empty: latency=%0d loads=%0d want 19 0", lat, loads);
    end
    take_result("mid_after");
  endtask

  initial begin
    rst = 1'b1;
    h.op_valid = 1'b0; h.op_index = '0; h.op_data = '0;
    h.go_valid = 1'b0; h.go_insn = '0; h.res_ready = 1'b0;
    result_in = '0;
    test_reset();
    test_min();
    test_madd();
    test_back_to_back();
    test_illegal();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
